// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer types and Gray/binary helpers.
// Helpers work on a fixed 32-bit container, so callers zero-extend narrower pointers and cast the result back.
// Zero-extension is harmless: the leading zero Gray bits decode to leading zero binary bits.
package fifo_pkg;

  localparam int PTR_WIDTH_DFLT = 9;
  localparam int FIFO_DEPTH     = 1 << PTR_WIDTH_DFLT;
  localparam int PTR_MAX_W      = 32;

  // Pointer type for the default geometry (address bits plus the wrap bit).
  typedef logic [PTR_WIDTH_DFLT:0] ptr_t;

  // Prefix XOR from the MSB down.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int popcount(input logic [PTR_MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/w2r_ptr_sync_lvl_chain.sv
// sync_chain: plain multi-flop CDC synchroniser, usable in either pointer direction.
// Latency: STAGES clock edges from i_d to o_q; o_q_pre is the value that o_q takes on the next edge.
// There is no logic between the stages, and every stage resets asynchronously to 0.
module sync_chain #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_pre
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q     = r_stage[STAGES-1];
  assign o_q_pre = r_stage[STAGES-2];

endmodule

// File: rtl/w2r_ptr_sync_lvl.sv
// w2r_ptr_sync_lvl: the read-domain receiver for the write Gray pointer. It synchronises the pointer, decodes it to binary, and derives the fill level and the empty and almost-empty flags.
// Latency: wptr_gray reaches wptr_sync_gray/bin after SYNC_STAGES rclk edges. The level and flags are registered from the *_next values.
// No backpressure. Optional macro GRAY_CHECK_EN adds a sticky multi-bit-step detector on the synchronised pointer.
module w2r_ptr_sync_lvl
  import fifo_pkg::*;
#(
  parameter int ptr_width     = 9,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic               rclk,
  input  logic               r_rst_n,
  input  logic [ptr_width:0] wptr_gray,
  input  logic [ptr_width:0] rptr_bin_next,
  output logic [ptr_width:0] wptr_sync_gray,
  output logic [ptr_width:0] wptr_sync_bin,
  output logic [ptr_width:0] rd_level,
  output logic               rempty,
  output logic               almost_empty,
  output logic               lvl_err,
  output logic               sync_err
);

  localparam int             PW       = ptr_width + 1;
  localparam logic [PW-1:0]  DEPTH_V  = {1'b1, {ptr_width{1'b0}}};
  localparam logic [PW-1:0]  THRESH_V = PW'(AEMPTY_THRESH);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("w2r_ptr_sync_lvl: SYNC_STAGES must be 2..4");
  end
  if (AEMPTY_THRESH < 1 || AEMPTY_THRESH > (1 << ptr_width) - 1) begin : g_bad_thresh
    $error("w2r_ptr_sync_lvl: AEMPTY_THRESH out of range");
  end

  logic [PW-1:0] w_sync_gray;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_lvl_raw;
  logic [PW-1:0] w_lvl_next;
  logic          w_overrun;

  logic [PW-1:0] r_wptr_sync_bin;
  logic [PW-1:0] r_rd_level;
  logic          r_rempty;
  logic          r_aempty;
  logic          r_lvl_err;

  sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (rclk),
    .i_rst_n (r_rst_n),
    .i_d     (wptr_gray),
    .o_q     (w_sync_gray),
    .o_q_pre (w_gray_next)
  );

  // Decode the value that is about to enter the last stage, so the binary pointer lands in the same cycle as the Gray one.
  assign w_bin_next = PW'(gray2bin(PTR_MAX_W'(w_gray_next)));

  // The modulo subtraction covers pointer wrap. Any result above DEPTH means a read overran the write pointer or a pointer was corrupted.
  assign w_lvl_raw  = w_bin_next - rptr_bin_next;
  assign w_overrun  = (w_lvl_raw > DEPTH_V);
  assign w_lvl_next = w_overrun ? DEPTH_V : w_lvl_raw;

  // Register the decoded pointer, the level and the flags from their next-state values.
  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_wptr_sync_bin <= '0;
      r_rd_level      <= '0;
      r_rempty        <= 1'b1;
      r_aempty        <= 1'b1;
      r_lvl_err       <= 1'b0;
    end else begin
      r_wptr_sync_bin <= w_bin_next;
      r_rd_level      <= w_lvl_next;
      r_rempty        <= (w_lvl_next == '0);
      r_aempty        <= (w_lvl_next <= THRESH_V);
      r_lvl_err       <= r_lvl_err | w_overrun;
    end
  end

`ifdef GRAY_CHECK_EN
  logic r_sync_err;

  // The last chain stage already holds the previous synchronised value, so comparing it with the incoming value needs no extra history flop.
  // After reset that previous value is 0.
  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_sync_err <= 1'b0;
    end else if (popcount(PTR_MAX_W'(w_gray_next ^ w_sync_gray)) > 1) begin
      r_sync_err <= 1'b1;
    end
  end

  assign sync_err = r_sync_err;
`else
  assign sync_err = 1'b0;
`endif

  assign wptr_sync_gray = w_sync_gray;
  assign wptr_sync_bin  = r_wptr_sync_bin;
  assign rd_level       = r_rd_level;
  assign rempty         = r_rempty;
  assign almost_empty   = r_aempty;
  assign lvl_err        = r_lvl_err;

endmodule

// File: tb/tb_w2r_ptr_sync_lvl.sv
// Bench for w2r_ptr_sync_lvl (ptr_width=9, SYNC_STAGES=3). A reference model pushes the expected outputs for every clock edge,
// and a negedge monitor pops and compares them. The scenario tasks add targeted inline checks.
module tb_w2r_ptr_sync_lvl;

  localparam int S     = 3;
  localparam int DEPTH = 512;
  localparam int TH    = 4;
`ifdef GRAY_CHECK_EN
  localparam logic EXP_SERR_ON_JUMP = 1'b1;
`else
  localparam logic EXP_SERR_ON_JUMP = 1'b0;
`endif

  logic       rclk = 1'b0;
  logic       r_rst_n;
  logic [9:0] wptr_gray;
  logic [9:0] rptr_bin_next;
  logic [9:0] wptr_sync_gray;
  logic [9:0] wptr_sync_bin;
  logic [9:0] rd_level;
  logic       rempty;
  logic       almost_empty;
  logic       lvl_err;
  logic       sync_err;

  typedef struct packed {
    logic [9:0] g;
    logic [9:0] b;
    logic [9:0] lvl;
    logic       emp;
    logic       ae;
    logic       lerr;
    logic       serr;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [9:0] m_hist[S];
  logic       m_lerr;
  logic       m_serr;

  always #5 rclk = ~rclk;

  w2r_ptr_sync_lvl #(
    .ptr_width     (9),
    .SYNC_STAGES   (S),
    .AEMPTY_THRESH (TH)
  ) dut (
    .rclk           (rclk),
    .r_rst_n        (r_rst_n),
    .wptr_gray      (wptr_gray),
    .rptr_bin_next  (rptr_bin_next),
    .wptr_sync_gray (wptr_sync_gray),
    .wptr_sync_bin  (wptr_sync_bin),
    .rd_level       (rd_level),
    .rempty         (rempty),
    .almost_empty   (almost_empty),
    .lvl_err        (lvl_err),
    .sync_err       (sync_err)
  );

  function automatic logic [9:0] m_g2b(input logic [9:0] g);
    logic [9:0] b;
    for (int i = 0; i < 10; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [9:0] b2g(input logic [9:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int popcnt(input logic [9:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) if (v[i]) n++;
    return n;
  endfunction

  // Drive one cycle's inputs, push the model's expectation for the coming edge, then wait until the next negedge.
  task automatic drive(input logic [9:0] g, input logic [9:0] rn);
    exp_t       e;
    logic [9:0] prev;
    logic [9:0] lvl;
    wptr_gray     = g;
    rptr_bin_next = rn;
    if (!r_rst_n) begin
      for (int i = 0; i < S; i++) m_hist[i] = '0;
      m_lerr = 1'b0;
      m_serr = 1'b0;
      e.g = '0; e.b = '0; e.lvl = '0; e.emp = 1'b1; e.ae = 1'b1; e.lerr = 1'b0; e.serr = 1'b0;
    end else begin
      prev = m_hist[S-1];
      for (int i = S-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = g;
      e.g = m_hist[S-1];
      e.b = m_g2b(e.g);
      lvl = e.b - rn;
      if (lvl > 10'd512) begin
        m_lerr = 1'b1;
        e.lvl = 10'd512; e.emp = 1'b0; e.ae = 1'b0;
      end else begin
        e.lvl = lvl; e.emp = (lvl == 0); e.ae = (lvl <= 10'(TH));
      end
      if (EXP_SERR_ON_JUMP && popcnt(prev ^ e.g) > 1) m_serr = 1'b1;
      e.lerr = m_lerr;
      e.serr = m_serr;
    end
    sb.push_back(e);
    @(posedge rclk);
    @(negedge rclk);
  endtask

  // Scoreboard monitor: pop and compare the expectation for each edge.
  always @(negedge rclk) begin
    exp_t e;
    exp_t got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = '{g: wptr_sync_gray, b: wptr_sync_bin, lvl: rd_level, emp: rempty,
              ae: almost_empty, lerr: lvl_err, serr: sync_err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got g=%h b=%h lvl=%0d emp=%b ae=%b lerr=%b serr=%b expected g=%h b=%h lvl=%0d emp=%b ae=%b lerr=%b serr=%b",
                 $time, got.g, got.b, got.lvl, got.emp, got.ae, got.lerr, got.serr,
                 e.g, e.b, e.lvl, e.emp, e.ae, e.lerr, e.serr);
      end
    end
  end

  task automatic apply_reset;
    r_rst_n = 1'b0;
    drive(10'h0, 10'h0);
    drive(10'h0, 10'h0);
    r_rst_n = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset();
    for (int i = 0; i < 4; i++) drive(10'h2A5, 10'h0);
    r_rst_n = 1'b0;
    #1;
    checks++;
    if ({wptr_sync_gray, wptr_sync_bin, rd_level} !== 30'h0) begin
      errors++;
      $display("FAIL reset_async_ptrs got g=%h b=%h lvl=%0d expected all 0", wptr_sync_gray, wptr_sync_bin, rd_level);
    end
    checks++;
    if ({rempty, almost_empty, lvl_err, sync_err} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_async_flags got %b expected 1100", {rempty, almost_empty, lvl_err, sync_err});
    end
    drive(10'h2A5, 10'h0);
    drive(10'h2A5, 10'h0);
    r_rst_n = 1'b1;
    for (int i = 1; i <= S; i++) begin
      drive(10'h2A5, 10'h0);
      checks++;
      if (wptr_sync_gray !== ((i < S) ? 10'h0 : 10'h2A5)) begin
        errors++;
        $display("FAIL reset_release_latency edge=%0d got %h expected %h", i, wptr_sync_gray, (i < S) ? 10'h0 : 10'h2A5);
      end
    end
  endtask

  task automatic test_latency;
    apply_reset();
    for (int i = 1; i <= S; i++) begin
      drive(10'h001, 10'h0);
      checks++;
      if (i < S) begin
        if (rempty !== 1'b1 || rd_level !== 10'd0) begin
          errors++;
          $display("FAIL latency_early edge=%0d got rempty=%b lvl=%0d expected 1/0", i, rempty, rd_level);
        end
      end else if (wptr_sync_bin !== 10'd1 || rd_level !== 10'd1 || rempty !== 1'b0 || almost_empty !== 1'b1) begin
        errors++;
        $display("FAIL latency_arrive got bin=%0d lvl=%0d emp=%b ae=%b expected 1/1/0/1", wptr_sync_bin, rd_level, rempty, almost_empty);
      end
    end
  endtask

  task automatic test_wrap;
    apply_reset();
    drive(b2g(10'h000), 10'h3FF);
    checks++;
    if (rd_level !== 10'd1) begin
      errors++;
      $display("FAIL wrap_level1 got %0d expected 1", rd_level);
    end
    for (int i = 0; i < S; i++) drive(b2g(10'h200), 10'h000);
    checks++;
    if (rd_level !== 10'd512 || rempty !== 1'b0 || lvl_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_full got lvl=%0d emp=%b lerr=%b expected 512/0/0", rd_level, rempty, lvl_err);
    end
  endtask

  task automatic test_threshold;
    apply_reset();
    for (int i = 0; i < S; i++) drive(b2g(10'd5), 10'd0);
    for (int i = 0; i < S-1; i++) drive(b2g(10'd6), 10'd0);
    drive(b2g(10'd6), 10'd1);
    checks++;
    if (rd_level !== 10'd5 || almost_empty !== 1'b0 || rempty !== 1'b0) begin
      errors++;
      $display("FAIL thresh_simul got lvl=%0d ae=%b emp=%b expected 5/0/0", rd_level, almost_empty, rempty);
    end
    drive(b2g(10'd6), 10'd2);
    checks++;
    if (rd_level !== 10'd4 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL thresh_edge got lvl=%0d ae=%b expected 4/1", rd_level, almost_empty);
    end
  endtask

  task automatic test_overrun;
    apply_reset();
    for (int i = 0; i < S; i++) drive(b2g(10'd10), 10'd0);
    drive(b2g(10'd10), 10'd11);
    checks++;
    if (lvl_err !== 1'b1 || rd_level !== 10'd512 || rempty !== 1'b0) begin
      errors++;
      $display("FAIL overrun_set got lerr=%b lvl=%0d emp=%b expected 1/512/0", lvl_err, rd_level, rempty);
    end
    drive(b2g(10'd10), 10'd10);
    checks++;
    if (lvl_err !== 1'b1 || rd_level !== 10'd0 || rempty !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky got lerr=%b lvl=%0d emp=%b expected 1/0/1", lvl_err, rd_level, rempty);
    end
    apply_reset();
    checks++;
    if (lvl_err !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %b expected 0", lvl_err);
    end
  endtask

  task automatic test_gray_check;
    apply_reset();
    for (int i = 1; i <= S; i++) begin
      drive(10'h003, 10'h0);
      checks++;
      if (sync_err !== ((i < S) ? 1'b0 : EXP_SERR_ON_JUMP)) begin
        errors++;
        $display("FAIL gray_check edge=%0d got %b expected %b", i, sync_err, (i < S) ? 1'b0 : EXP_SERR_ON_JUMP);
      end
    end
  endtask

  // Streaming writes and reads across a full pointer wrap. Reads never pass the synchronised write pointer.
  task automatic test_back_to_back;
    logic [9:0] wb;
    logic [9:0] rb;
    logic [9:0] d;
    int         nonempty;
    wb = '0;
    rb = '0;
    nonempty = 0;
    apply_reset();
    for (int n = 0; n < 1200; n++) begin
      d = wb - rb;
      if ($urandom_range(0, 3) != 0 && d < 10'd512) wb = wb + 10'd1;
      if ($urandom_range(0, 2) != 0 && rb != m_g2b(m_hist[S-2])) rb = rb + 10'd1;
      drive(b2g(wb), rb);
      if (!rempty) nonempty++;
    end
    checks++;
    if (lvl_err !== 1'b0 || nonempty == 0) begin
      errors++;
      $display("FAIL back_to_back got lerr=%b nonempty_cycles=%0d expected 0 and >0", lvl_err, nonempty);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    r_rst_n       = 1'b0;
    wptr_gray     = '0;
    rptr_bin_next = '0;
    test_reset();
    test_latency();
    test_wrap();
    test_threshold();
    test_overrun();
    test_gray_check();
    test_back_to_back();
    @(negedge rclk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
